// File: rtl/spi_adc_deframer.sv
// ---------------------------------------------------------------------------
// spi_adc_deframer
//
// Takes raw 32-bit words from an SPI master and extracts an ADC sample from
// each one. The sample is sign- or zero-extended, an offset is added, and the
// word is tagged with its channel index within the conversion frame. Results
// go through a small first-word-fall-through buffer to an AXI-stream master
// port. The SPI side cannot be stalled. When a word arrives and the buffer is
// full, the word is dropped and a sticky overflow flag is set.
//
// Ports
//   clock           system clock
//   reset           asynchronous, active-high reset
//   spi_data_in     raw word from the SPI master
//   spi_data_valid  single-cycle strobe qualifying spi_data_in
//   frame_start     conversion-start pulse; realigns the channel counter to 0
//   cfg_shift       logical right shift applied to the raw word
//   cfg_signed      1 = sign-extend the sample, 0 = zero-extend
//   cfg_offset      signed offset added to the extended sample
//   clear_overflow  clears the sticky overflow flag
//   m_tdata         processed sample
//   m_tdest         channel index of the sample
//   m_tlast         high on the last channel of a frame
//   m_tvalid        AXI-stream valid
//   m_tready        AXI-stream ready
//   overflow        sticky flag: a word was dropped because the buffer was full
// ---------------------------------------------------------------------------
module spi_adc_deframer #(
   parameter int SAMPLE_WIDTH = 16,
   parameter int N_CHANNELS   = 4,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] spi_data_in,
   input  logic        spi_data_valid,
   input  logic        frame_start,
   input  logic [4:0]  cfg_shift,
   input  logic        cfg_signed,
   input  logic [15:0] cfg_offset,
   input  logic        clear_overflow,
   output logic [31:0] m_tdata,
   output logic [7:0]  m_tdest,
   output logic        m_tlast,
   output logic        m_tvalid,
   input  logic        m_tready,
   output logic        overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_CNT   = CNT_W'(FIFO_DEPTH);
   localparam logic [7:0]       LAST_CH     = 8'(N_CHANNELS - 1);
   // Ones in the low SAMPLE_WIDTH bits. This form also works when
   // SAMPLE_WIDTH is 32, where a zero-width replication would be illegal.
   localparam logic [31:0]      SAMPLE_MASK = 32'hFFFF_FFFF >> (32 - SAMPLE_WIDTH);

   typedef struct packed {
      logic [31:0] data;
      logic [7:0]  dest;
      logic        last;
   } entry_t;

   // ---------------- extraction and channel tagging ----------------
   logic [31:0] raw;
   logic [31:0] ext_sample;
   logic [31:0] result;
   logic [7:0]  chan_cnt;
   logic [7:0]  tag;
   logic [7:0]  tag_next;

   // NOTE: every signal assigned in always_comb gets a value on every path;
   // otherwise a latch is inferred.
   always_comb begin
      raw = spi_data_in >> cfg_shift;
      if (cfg_signed && raw[SAMPLE_WIDTH-1])
         ext_sample = raw | ~SAMPLE_MASK;
      else
         ext_sample = raw & SAMPLE_MASK;
      result = ext_sample + {{16{cfg_offset[15]}}, cfg_offset};
      // frame_start in the same cycle as a word tags that word as channel 0.
      tag      = frame_start ? 8'd0 : chan_cnt;
      tag_next = (tag == LAST_CH) ? 8'd0 : tag + 8'd1;
   end

   // NOTE: sequential state uses non-blocking assignments so that every
   // register samples values from before the edge, regardless of block order.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         chan_cnt <= '0;
      else if (spi_data_valid)
         chan_cnt <= tag_next;      // advances even if the word is later dropped
      else if (frame_start)
         chan_cnt <= '0;
   end

   // ---------------- processing stage register ----------------
   logic   stg_valid;
   entry_t stg;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stg_valid <= 1'b0;
         stg       <= '0;
      end else begin
         stg_valid <= spi_data_valid;
         if (spi_data_valid)
            stg <= '{data: result, dest: tag, last: (tag == LAST_CH)};
      end
   end

   // ---------------- output buffer ----------------
   // The buffer is a circular memory that feeds an output register.
   // FIFO_DEPTH counts the memory entries plus the output register. A word
   // written to the memory moves to the output register on the next edge.
   entry_t            mem [FIFO_DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  mem_cnt;
   logic [CNT_W-1:0]  total;
   logic              out_valid;
   entry_t            out_q;
   logic              full;
   logic              rd;
   logic              wr;
   logic              load;
   logic              drop;

   assign total = mem_cnt + CNT_W'(out_valid);
   assign full  = (total == DEPTH_CNT);
   assign rd    = out_valid & m_tready;
   // Reading in the same cycle frees a slot, so a write at full succeeds.
   assign wr    = stg_valid & (~full | rd);
   assign drop  = stg_valid & full & ~rd;
   assign load  = (~out_valid | rd) & (mem_cnt != '0);

   // NOTE: the storage array is not reset. Occupancy is tracked by the
   // pointers and count, and an entry is never read before it is written.
   always_ff @(posedge clock) begin
      if (wr)
         mem[wr_ptr] <= stg;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         mem_cnt   <= '0;
         out_valid <= 1'b0;
         out_q     <= '0;
      end else begin
         if (wr)
            wr_ptr <= wr_ptr + PTR_W'(1);
         if (load)
            rd_ptr <= rd_ptr + PTR_W'(1);
         mem_cnt <= mem_cnt + CNT_W'(wr) - CNT_W'(load);
         if (load) begin
            out_valid <= 1'b1;
            out_q     <= mem[rd_ptr];
         end else if (rd) begin
            out_valid <= 1'b0;
         end
      end
   end

   // A drop in the same cycle as clear_overflow leaves the flag set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         overflow <= 1'b0;
      else if (drop)
         overflow <= 1'b1;
      else if (clear_overflow)
         overflow <= 1'b0;
   end

   assign m_tvalid = out_valid;
   assign m_tdata  = out_q.data;
   assign m_tdest  = out_q.dest;
   assign m_tlast  = out_q.last;

endmodule

// File: tb/tb_spi_adc_deframer.sv
// ---------------------------------------------------------------------------
// tb_spi_adc_deframer
//
// Directed self-checking bench for spi_adc_deframer with the default
// parameters (16-bit samples, 4 channels, 4-entry buffer). Inputs change 1 ns
// after the rising edge. Outputs are sampled at that same point or on the
// falling edge, so no value is read at the active edge.
// ---------------------------------------------------------------------------
module tb_spi_adc_deframer;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] spi_data_in;
   logic        spi_data_valid;
   logic        frame_start;
   logic [4:0]  cfg_shift;
   logic        cfg_signed;
   logic [15:0] cfg_offset;
   logic        clear_overflow;
   logic [31:0] m_tdata;
   logic [7:0]  m_tdest;
   logic        m_tlast;
   logic        m_tvalid;
   logic        m_tready;
   logic        overflow;

   int vectors     = 0;
   int miscompares = 0;

   // Completed transfers, packed as {data, dest, last}.
   logic [40:0] cap_q [$];

   spi_adc_deframer #(
      .SAMPLE_WIDTH (16),
      .N_CHANNELS   (4),
      .FIFO_DEPTH   (4)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .spi_data_in    (spi_data_in),
      .spi_data_valid (spi_data_valid),
      .frame_start    (frame_start),
      .cfg_shift      (cfg_shift),
      .cfg_signed     (cfg_signed),
      .cfg_offset     (cfg_offset),
      .clear_overflow (clear_overflow),
      .m_tdata        (m_tdata),
      .m_tdest        (m_tdest),
      .m_tlast        (m_tlast),
      .m_tvalid       (m_tvalid),
      .m_tready       (m_tready),
      .overflow       (overflow)
   );

   always #5 clock = ~clock;

   // Record a transfer when valid and ready are both high in mid-cycle.
   always @(negedge clock)
      if (!reset && m_tvalid && m_tready)
         cap_q.push_back({m_tdata, m_tdest, m_tlast});

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic apply_reset();
      reset          = 1'b1;
      spi_data_valid = 1'b0;
      frame_start    = 1'b0;
      clear_overflow = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      cap_q.delete();
      cyc();
   endtask

   task automatic set_cfg(input logic [4:0] sh, input logic sg, input logic [15:0] off);
      cfg_shift  = sh;
      cfg_signed = sg;
      cfg_offset = off;
   endtask

   task automatic send(input logic [31:0] d);
      spi_data_in    = d;
      spi_data_valid = 1'b1;
      cyc();
      spi_data_valid = 1'b0;
   endtask

   task automatic wait_cap(input int n, input string name);
      int t = 0;
      while (cap_q.size() < n && t < 100) begin
         cyc();
         t++;
      end
      repeat (4) cyc();
      vectors++;
      if (cap_q.size() != n) begin
         miscompares++;
         $display("FAIL %s count: got %0d words, expected %0d", name, cap_q.size(), n);
      end
   endtask

   function automatic logic [40:0] cap_at(input int i);
      if (i < cap_q.size())
         return cap_q[i];
      return 'x;
   endfunction

   // ---------------------------------------------------------------
   task automatic test_reset();
      reset = 1'b1;
      #2;
      vectors++;
      if ({m_tvalid, m_tdata, m_tdest, m_tlast, overflow} !== 43'd0) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b d=%h dest=%h l=%b ov=%b, expected all zero",
                  m_tvalid, m_tdata, m_tdest, m_tlast, overflow);
      end
   endtask

   task automatic test_zero_extend();
      apply_reset();
      m_tready = 1'b1;
      set_cfg(5'd2, 1'b0, 16'h0000);
      spi_data_in    = 32'h0003_FFFC;
      spi_data_valid = 1'b1;
      cyc();
      spi_data_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if (m_tvalid !== (i == 2)) begin
            miscompares++;
            $display("FAIL zext_latency edge %0d: m_tvalid=%b expected %b", i + 1, m_tvalid, (i == 2));
         end
         if (i < 2) cyc();
      end
      vectors++;
      if (m_tdata !== 32'h0000_FFFF || m_tdest !== 8'd0) begin
         miscompares++;
         $display("FAIL zext_data: got %h/%0d expected 0000ffff/0", m_tdata, m_tdest);
      end
      cyc();
   endtask

   // Config changes on every strobe, so each word must use its own settings.
   task automatic test_extract();
      logic [31:0] d_t   [7] = '{32'h0000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                                  32'hABCD_1234, 32'hABCD_1234, 32'h0003_FFFC};
      logic [4:0]  sh_t  [7] = '{5'd0, 5'd0, 5'd0, 5'd31, 5'd16, 5'd16, 5'd2};
      logic        sg_t  [7] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [15:0] off_t [7] = '{16'h0010, 16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000};
      logic [31:0] exp_t [7] = '{32'hFFFF_8010, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001,
                                  32'hFFFF_ABCD, 32'h0001_2BCC, 32'hFFFF_FFFF};
      logic [40:0] e;
      apply_reset();
      m_tready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         set_cfg(sh_t[i], sg_t[i], off_t[i]);
         send(d_t[i]);
      end
      set_cfg(5'd0, 1'b0, 16'h0000);
      wait_cap(7, "extract");
      for (int i = 0; i < 7; i++) begin
         e = cap_at(i);
         vectors++;
         if (e[40:9] !== exp_t[i]) begin
            miscompares++;
            $display("FAIL extract[%0d]: got %h expected %h", i, e[40:9], exp_t[i]);
         end
      end
   endtask

   task automatic test_channel_seq();
      logic [40:0] e;
      apply_reset();
      m_tready = 1'b1;
      set_cfg(5'd0, 1'b0, 16'h0000);
      for (int i = 0; i < 6; i++) send(32'h10 + 32'(i));
      wait_cap(6, "chan_seq");
      for (int i = 0; i < 6; i++) begin
         e = cap_at(i);
         vectors++;
         if (e[8:1] !== 8'(i % 4) || e[0] !== (i == 3)) begin
            miscompares++;
            $display("FAIL chan_seq[%0d]: got dest=%0d last=%b expected dest=%0d last=%b",
                     i, e[8:1], e[0], i % 4, (i == 3));
         end
      end
   endtask

   task automatic test_realign();
      logic [7:0]  exp_d [7] = '{8'd0, 8'd1, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1};
      logic [40:0] e;
      apply_reset();
      m_tready = 1'b1;
      set_cfg(5'd0, 1'b0, 16'h0000);
      send(32'h20);
      send(32'h21);
      frame_start = 1'b1;
      cyc();
      frame_start = 1'b0;
      send(32'h22);
      send(32'h23);
      send(32'h24);
      frame_start = 1'b1;            // coincident with the next strobe
      send(32'h25);
      frame_start = 1'b0;
      send(32'h26);
      wait_cap(7, "realign");
      for (int i = 0; i < 7; i++) begin
         e = cap_at(i);
         vectors++;
         if (e[8:1] !== exp_d[i] || e[40:9] !== 32'h20 + 32'(i)) begin
            miscompares++;
            $display("FAIL realign[%0d]: got dest=%0d data=%h expected dest=%0d data=%h",
                     i, e[8:1], e[40:9], exp_d[i], 32'h20 + 32'(i));
         end
      end
   endtask

   task automatic test_overflow();
      logic [40:0] e;
      apply_reset();
      m_tready = 1'b0;
      set_cfg(5'd0, 1'b0, 16'h0000);
      for (int i = 0; i < 6; i++) send(32'h100 + 32'(i));
      repeat (4) cyc();
      vectors++;
      if (overflow !== 1'b1 || m_tvalid !== 1'b1 || m_tdata !== 32'h100) begin
         miscompares++;
         $display("FAIL ovf_stall: got ov=%b v=%b d=%h expected 1/1/00000100", overflow, m_tvalid, m_tdata);
      end
      m_tready = 1'b1;
      wait_cap(4, "ovf_drain");
      for (int i = 0; i < 4; i++) begin
         e = cap_at(i);
         vectors++;
         if (e[40:9] !== 32'h100 + 32'(i) || e[8:1] !== 8'(i)) begin
            miscompares++;
            $display("FAIL ovf_drain[%0d]: got %h/%0d expected %h/%0d",
                     i, e[40:9], e[8:1], 32'h100 + 32'(i), i);
         end
      end
      vectors++;
      if (overflow !== 1'b1) begin
         miscompares++;
         $display("FAIL ovf_sticky: got %b expected 1", overflow);
      end
      clear_overflow = 1'b1;
      cyc();
      clear_overflow = 1'b0;
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL ovf_clear: got %b expected 0", overflow);
      end
      // Six strobes advanced the counter to 2, including the two dropped words.
      cap_q.delete();
      send(32'h1FF);
      wait_cap(1, "ovf_after");
      e = cap_at(0);
      vectors++;
      if (e[8:1] !== 8'd2) begin
         miscompares++;
         $display("FAIL ovf_counter: got dest=%0d expected 2", e[8:1]);
      end
   endtask

   // The buffer fills while stalled. Ready rises just as the fifth word
   // reaches a full buffer, so that write must succeed alongside the read.
   task automatic test_back_to_back();
      logic [40:0] e;
      apply_reset();
      m_tready = 1'b0;
      set_cfg(5'd0, 1'b0, 16'h0000);
      for (int i = 0; i < 8; i++) begin
         if (i == 5) m_tready = 1'b1;
         send(32'h200 + 32'(i));
      end
      wait_cap(8, "b2b");
      for (int i = 0; i < 8; i++) begin
         e = cap_at(i);
         vectors++;
         if (e[40:9] !== 32'h200 + 32'(i)) begin
            miscompares++;
            $display("FAIL b2b[%0d]: got %h expected %h", i, e[40:9], 32'h200 + 32'(i));
         end
      end
      vectors++;
      if (overflow !== 1'b0) begin
         miscompares++;
         $display("FAIL b2b_overflow: got %b expected 0", overflow);
      end
   endtask

   task automatic test_reset_midstream();
      logic [40:0] e;
      apply_reset();
      m_tready = 1'b0;
      set_cfg(5'd0, 1'b0, 16'h0000);
      for (int i = 0; i < 3; i++) send(32'h300 + 32'(i));
      repeat (3) cyc();
      vectors++;
      if (m_tvalid !== 1'b1) begin
         miscompares++;
         $display("FAIL mid_before: m_tvalid=%b expected 1", m_tvalid);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if ({m_tvalid, m_tdata, m_tdest, m_tlast, overflow} !== 43'd0) begin
         miscompares++;
         $display("FAIL mid_reset: got v=%b d=%h dest=%h l=%b ov=%b, expected all zero",
                  m_tvalid, m_tdata, m_tdest, m_tlast, overflow);
      end
      cyc();
      cyc();
      reset    = 1'b0;
      cap_q.delete();
      m_tready = 1'b1;
      cyc();
      send(32'h3AA);
      wait_cap(1, "mid_after");
      e = cap_at(0);
      vectors++;
      if (e[8:1] !== 8'd0 || e[40:9] !== 32'h3AA) begin
         miscompares++;
         $display("FAIL mid_after: got %h/%0d expected 000003aa/0", e[40:9], e[8:1]);
      end
   endtask

   initial begin
      spi_data_in    = '0;
      spi_data_valid = 1'b0;
      frame_start    = 1'b0;
      clear_overflow = 1'b0;
      m_tready       = 1'b0;
      set_cfg(5'd0, 1'b0, 16'h0000);
      test_reset();
      test_zero_extend();
      test_extract();
      test_channel_seq();
      test_realign();
      test_overflow();
      test_back_to_back();
      test_reset_midstream();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/spi_adc_deframer.md
SPI_ADC_DEFRAMER -- requirements
Module: spi_adc_deframer

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 Parameter SAMPLE_WIDTH, default 16, meaning extracted ADC sample width in bits (2..32).
REQ-003 Parameter N_CHANNELS, default 4, meaning ADC channels per conversion frame (1..256).
REQ-004 Parameter FIFO_DEPTH, default 4, meaning output buffer entries (power of two, >=2).
REQ-005 Ports SHALL be:
- clock  in  1  system clock
- reset  in  1  async active-high reset
- spi_data_in  in  32  raw word from SPI master
- spi_data_valid  in  1  single-cycle strobe, spi_data_in valid
- frame_start  in  1  conversion-start pulse; realigns channel counter
- cfg_shift  in  5  right shift applied to raw word
- cfg_signed  in  1  1 = sign-extend sample, 0 = zero-extend
- cfg_offset  in  16  signed offset added to sample
- clear_overflow  in  1  clears sticky overflow
- m_tdata  out  32  processed sample
- m_tdest  out  8  channel index
- m_tlast  out  1  last channel of frame
- m_tvalid  out  1  AXI-stream valid
- m_tready  in  1  AXI-stream ready
- overflow  out  1  sticky dropped-word flag

Function
REQ-006 Extraction SHALL be: raw = spi_data_in >> cfg_shift (logical); sample = raw[SAMPLE_WIDTH-1:0].
REQ-007 Extension SHALL be to 32 bits: sign-extend from bit SAMPLE_WIDTH-1 if cfg_signed=1, else zero-extend.
REQ-008 Result SHALL be extended sample + sign-extended cfg_offset, modulo 2^32 (wrap, no saturation).
REQ-009 Config inputs SHALL be sampled in the same cycle as spi_data_valid.
REQ-010 Processing SHALL be one register stage: word accepted at edge k is written to the FIFO at edge k+1; m_tvalid SHALL be high after edge k+2 when the FIFO was empty and no stall.
REQ-011 Channel counter SHALL start at 0, tag each accepted word with its current value, then increment, wrapping from N_CHANNELS-1 to 0.
REQ-012 m_tlast SHALL be 1 exactly when tagged channel = N_CHANNELS-1; N_CHANNELS=1 gives m_tlast on every word.
REQ-013 frame_start SHALL force the counter to 0; if simultaneous with spi_data_valid, that word SHALL be tagged 0 and the counter SHALL become 1 (or 0 if N_CHANNELS=1).
REQ-014 FIFO SHALL be first-word-fall-through; m_tdata/m_tdest/m_tlast SHALL be stable while m_tvalid=1 and m_tready=0.
REQ-015 A transfer SHALL occur on an edge with m_tvalid=1 and m_tready=1; the next entry SHALL present on the following cycle.
REQ-016 Simultaneous FIFO write and read SHALL be allowed at any occupancy, including full (write then succeeds).
REQ-017 A word reaching a full FIFO with no simultaneous read SHALL be dropped, overflow SHALL set, and the channel counter SHALL still advance.
REQ-018 overflow SHALL stay set until clear_overflow=1; simultaneous set and clear SHALL leave overflow=1.
REQ-019 There SHALL be no upstream backpressure; spi_data_valid on consecutive cycles SHALL be accepted.

Reset
REQ-020 On reset assertion, outputs SHALL immediately be: m_tvalid=0, m_tdata=0, m_tdest=0, m_tlast=0, overflow=0.
REQ-021 Reset SHALL empty the FIFO, clear the stage register and zero the channel counter; any in-flight word SHALL be discarded.
REQ-022 First accepted word after reset deassertion SHALL be tagged channel 0.

Verification
REQ-023 The bench SHALL cover the following scenarios:
- Zero-extend: SAMPLE_WIDTH=16, cfg_shift=2, cfg_signed=0, cfg_offset=0, raw 0x0003_FFFC, m_tready=1 -> m_tdata=0x0000_FFFF, m_tdest=0, m_tvalid 2 cycles after the strobe.
- Sign-extend and offset: cfg_shift=0, cfg_signed=1, cfg_offset=0x0010, raw 0x0000_8000 -> m_tdata=0xFFFF_8010.
- Channel sequence: N_CHANNELS=4, six words, no frame_start -> m_tdest 0,1,2,3,0,1; m_tlast only on the 4th word.
- Realignment: frame_start after two words, then three words -> m_tdest 0,1,0,1,2; frame_start coincident with a strobe -> that word tagged 0.
- Overflow: m_tready=0, six strobes with FIFO_DEPTH=4 -> 4 words held, overflow=1; then m_tready=1 -> the 4 oldest words out in order; then clear_overflow -> overflow=0.
- Reset mid-stream: assert reset with 3 words buffered and m_tready=0 -> m_tvalid=0 immediately; after release, next word tagged channel 0.
